des_key_sched_seq: RTL and testbench

- Iterative, handshaked DES key-schedule engine that emits one 48-bit round subkey per cycle, instead of presenting all subkeys in parallel.
- Supports encrypt order (K1..K16, left rotations) and decrypt order (K16..K1, right rotations) with a parametrised shift schedule.
- Sits between key load and the round datapath. It feeds a pipelined or iterative Feistel core through a valid/ready stream with backpressure.

---
 rtl/des_pkg.sv | 71 +++++++
 rtl/des_cd_rotator.sv | 21 ++
 rtl/des_key_sched_seq_chk.sv | 29 ++
 rtl/des_key_sched_seq.sv | 170 +++++++++++++++++
 tb/tb_des_key_sched_seq.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared types, permutation tables and bit-level helpers for the DES key schedule.
// Bit numbering follows DES: bit 1 is the MSB of each vector.
package des_pkg;

  typedef logic [27:0] half28_t;
  typedef logic [55:0] cd56_t;
  typedef logic [47:0] subkey48_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } ks_state_t;

  localparam logic [15:0] DES_SHIFT_MASK = 16'h8103;

  localparam logic [6:0] PC1_TAB [56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Parity bits never appear in PC1, so they drop out here.
  function automatic cd56_t pc1(input logic [63:0] key);
    cd56_t cd;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(7'd64 - PC1_TAB[6'(i)])];
    end
    return cd;
  endfunction

  function automatic subkey48_t pc2(input cd56_t cd);
    subkey48_t sk;
    sk = '0;
    for (int i = 0; i < 48; i++) begin
      sk[6'(47 - i)] = cd[6'd56 - PC2_TAB[6'(i)]];
    end
    return sk;
  endfunction

  function automatic half28_t rol28(input half28_t h, input logic [1:0] amt);
    return (amt == 2'd2) ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction

  function automatic half28_t ror28(input half28_t h, input logic [1:0] amt);
    return (amt == 2'd2) ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction

  // Rotation amount for 1-based round r.
  function automatic logic [1:0] shift_amt(input logic [15:0] mask, input logic [4:0] r);
    return mask[4'(r - 5'd1)] ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/des_cd_rotator.sv
// Rotates the C and D halves of a 56-bit key state independently by 1 or 2 positions.
module des_cd_rotator
  import des_pkg::*;
(
  input  cd56_t      cd,
  input  logic [1:0] amount,
  input  logic       dir,
  output cd56_t      cd_next
);

  half28_t c_s;
  half28_t d_s;

  assign c_s = cd[55:28];
  assign d_s = cd[27:0];

  // dir=1 selects right rotation (decrypt order).
  assign cd_next = dir ? {ror28(c_s, amount), ror28(d_s, amount)}
                       : {rol28(c_s, amount), rol28(d_s, amount)};

endmodule

// File: rtl/des_key_sched_seq_chk.sv
// Checker: decrypt order is only meaningful when the whole schedule rotates by a
// multiple of 28 positions.
module des_key_sched_seq_chk #(
  parameter int unsigned ROUNDS     = 16,
  parameter logic [15:0] SHIFT_MASK = 16'h8103
) (
  input logic clk,
  input logic rst_n,
  input logic start_i,
  input logic ready_o,
  input logic mode_i
);

  function automatic int unsigned total_rot();
    int unsigned t;
    t = 32'd0;
    for (int r = 0; r < int'(ROUNDS); r++) begin
      t += SHIFT_MASK[4'(r)] ? 32'd1 : 32'd2;
    end
    return t;
  endfunction

  localparam int unsigned TOTAL_ROT = total_rot();

  a_dec_rot: assert property (@(posedge clk) disable iff (!rst_n)
      (start_i && ready_o && mode_i) |-> ((TOTAL_ROT % 32'd28) == 32'd0))
    else $error("decrypt order undefined: total rotation %0d", TOTAL_ROT);

endmodule

// File: rtl/des_key_sched_seq.sv
// Iterative DES key schedule: emits one 48-bit subkey per accepted transfer on a
// valid/ready stream, in encrypt (K1..Kn) or decrypt (Kn..K1) order.
module des_key_sched_seq
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS     = 16,
  parameter logic [15:0] SHIFT_MASK = DES_SHIFT_MASK
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic [63:0] key_i,
  output logic        ready_o,
  output logic [47:0] subkey_o,
  output logic        subkey_valid_o,
  input  logic        subkey_ready_i,
  output logic [4:0]  round_o,
  output logic        last_o,
  output logic        done_o
);

  localparam logic [4:0] LAST_CNT = 5'(ROUNDS - 1);
  localparam logic [4:0] ROUNDS_W = 5'(ROUNDS);

  ks_state_t  state_r, state_s;
  cd56_t      cd_r, cd_s;
  logic [4:0] cnt_r, cnt_s;
  logic       mode_r, mode_s;
  subkey48_t  subkey_r, subkey_s;
  logic       valid_r, valid_s;
  logic [4:0] round_r, round_s;
  logic       last_r, last_s;
  logic       done_r, done_s;
  logic       ready_r, ready_s;

  cd56_t      key_cd_s;
  cd56_t      rot_in_s;
  cd56_t      rot_out_s;
  logic [1:0] rot_amt_s;
  logic       rot_dir_s;
  logic       advance_s;

  assign key_cd_s  = pc1(key_i);
  assign advance_s = !valid_r || subkey_ready_i;

  // Rotator operand: the loaded key while idle, the running C/D state otherwise.
  always_comb begin
    if (state_r == ST_RUN) begin
      rot_in_s  = cd_r;
      rot_dir_s = mode_r;
      rot_amt_s = mode_r ? shift_amt(SHIFT_MASK, ROUNDS_W - cnt_r)
                         : shift_amt(SHIFT_MASK, cnt_r + 5'd2);
    end else begin
      rot_in_s  = key_cd_s;
      rot_dir_s = 1'b0;
      rot_amt_s = shift_amt(SHIFT_MASK, 5'd1);
    end
  end

  des_cd_rotator u_rot (
    .cd      (rot_in_s),
    .amount  (rot_amt_s),
    .dir     (rot_dir_s),
    .cd_next (rot_out_s)
  );

  // Next-state and output-stage logic.
  always_comb begin
    state_s  = state_r;
    cd_s     = cd_r;
    cnt_s    = cnt_r;
    mode_s   = mode_r;
    subkey_s = subkey_r;
    valid_s  = valid_r;
    round_s  = round_r;
    last_s   = last_r;
    done_s   = 1'b0;
    if (clear_i) begin
      state_s = ST_IDLE;
      valid_s = 1'b0;
      last_s  = 1'b0;
      cnt_s   = 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i && ready_r) begin
            mode_s  = mode_i;
            // Decrypt starts from C0D0, which equals C16D16 after a full 28-bit turn.
            cd_s    = mode_i ? key_cd_s : rot_out_s;
            cnt_s   = 5'd0;
            state_s = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (advance_s) begin
            subkey_s = pc2(cd_r);
            valid_s  = 1'b1;
            round_s  = mode_r ? (ROUNDS_W - cnt_r) : (cnt_r + 5'd1);
            last_s   = (cnt_r == LAST_CNT);
            cnt_s    = cnt_r + 5'd1;
            if (cnt_r == LAST_CNT) begin
              state_s = ST_FLUSH;
            end else begin
              cd_s = rot_out_s;
            end
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (valid_r && subkey_ready_i) begin
            valid_s = 1'b0;
            last_s  = 1'b0;
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_FLUSH;
          end
        end
        default: begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
          last_s  = 1'b0;
          cnt_s   = 5'd0;
        end
      endcase
    end
    // ready follows done by one cycle.
    ready_s = (state_s == ST_IDLE) && !done_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cd_r     <= '0;
      cnt_r    <= 5'd0;
      mode_r   <= 1'b0;
      subkey_r <= '0;
      valid_r  <= 1'b0;
      round_r  <= 5'd0;
      last_r   <= 1'b0;
      done_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      state_r  <= state_s;
      cd_r     <= cd_s;
      cnt_r    <= cnt_s;
      mode_r   <= mode_s;
      subkey_r <= subkey_s;
      valid_r  <= valid_s;
      round_r  <= round_s;
      last_r   <= last_s;
      done_r   <= done_s;
      ready_r  <= ready_s;
    end
  end

  assign ready_o        = ready_r;
  assign subkey_o       = subkey_r;
  assign subkey_valid_o = valid_r;
  assign round_o        = round_r;
  assign last_o         = last_r;
  assign done_o         = done_r;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Self-checking bench for des_key_sched_seq: known-answer table, a cumulative-rotation
// reference model, and hand-written backpressure/clear/reset sequences.
module tb_des_key_sched_seq;

  localparam int          ROUNDS = 16;
  localparam logic [15:0] MASK   = 16'h8103;
  localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;

  logic        clk = 1'b0;
  logic        rst_n, clear_i, start_i, mode_i, subkey_ready_i;
  logic [63:0] key_i;
  logic        ready_o, subkey_valid_o, last_o, done_o;
  logic [47:0] subkey_o;
  logic [4:0]  round_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  des_key_sched_seq #(.ROUNDS(ROUNDS), .SHIFT_MASK(MASK)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .start_i(start_i), .mode_i(mode_i),
    .key_i(key_i), .ready_o(ready_o), .subkey_o(subkey_o), .subkey_valid_o(subkey_valid_o),
    .subkey_ready_i(subkey_ready_i), .round_o(round_o), .last_o(last_o), .done_o(done_o)
  );

  des_key_sched_seq_chk #(.ROUNDS(ROUNDS), .SHIFT_MASK(MASK)) u_chk (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .ready_o(ready_o), .mode_i(mode_i)
  );

  int PC1_T[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2_T[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  // Subkey K_r: C0/D0 rotated left by the cumulative shift of rounds 1..r, then PC2.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
    logic cd [1:56];
    logic rc [1:56];
    logic [47:0] k;
    int t;
    t = 0;
    for (int i = 1; i <= r; i++) t += MASK[4'(i - 1)] ? 1 : 2;
    for (int j = 1; j <= 56; j++) cd[j] = key[64 - PC1_T[j - 1]];
    for (int j = 1; j <= 28; j++) begin
      rc[j]      = cd[((j - 1 + t) % 28) + 1];
      rc[j + 28] = cd[((j - 1 + t) % 28) + 29];
    end
    for (int b = 1; b <= 48; b++) k[48 - b] = rc[PC2_T[b - 1]];
    return k;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  logic [47:0] cap_sk [ROUNDS];
  logic [4:0]  cap_rd [ROUNDS];
  logic        cap_last [ROUNDS];
  logic [47:0] enc_sk [ROUNDS];
  logic [4:0]  enc_rd [ROUNDS];
  logic        enc_last [ROUNDS];
  logic [47:0] dec_sk [ROUNDS];
  logic [4:0]  dec_rd [ROUNDS];
  logic        dec_last [ROUNDS];

  // One full key operation. stall_idx>=0 holds ready low 3 cycles while that transfer is shown.
  task automatic run_op(input logic mode, input logic [63:0] key, input bit rand_stall,
                        input int stall_idx, input bit noise);
    int idx, cyc, first, stall_left;
    bit stalled_once, fin;
    logic [4:0] exp_r;
    idx = 0; cyc = 0; first = -1; stall_left = 0; stalled_once = 0; fin = 0;
    @(negedge clk);
    chk("ready_before_start", ready_o, 1'b1);
    start_i = 1'b1; mode_i = mode; key_i = key; subkey_ready_i = 1'b1;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start_i = noise && ($urandom_range(0, 3) == 0);
      mode_i  = 1'($urandom);
      key_i   = {$urandom, $urandom};
      if (rand_stall) subkey_ready_i = ($urandom_range(0, 2) != 0);
      else if (stall_left > 0) begin subkey_ready_i = 1'b0; stall_left--; end
      else if (!stalled_once && subkey_valid_o && idx == stall_idx) begin
        subkey_ready_i = 1'b0; stall_left = 2; stalled_once = 1;
      end
      else subkey_ready_i = 1'b1;
      chk("ready_busy", ready_o, 1'b0);
      if (subkey_valid_o) begin
        if (first < 0) begin
          first = cyc;
          chk("first_valid_latency", first, 2);
        end
        if (idx < ROUNDS) begin
          exp_r = mode ? 5'(ROUNDS - idx) : 5'(idx + 1);
          chk("round", round_o, exp_r);
          chk("subkey", subkey_o, ref_subkey(key, int'(exp_r)));
          chk("last", last_o, idx == ROUNDS - 1);
          if (subkey_ready_i) begin
            cap_sk[idx] = subkey_o; cap_rd[idx] = round_o; cap_last[idx] = last_o;
            idx++;
          end
        end else begin
          chk("valid_after_final", subkey_valid_o, 1'b0);
        end
      end
      if (done_o) begin
        fin = 1;
        chk("count_at_done", idx, ROUNDS);
        if (!rand_stall && stall_idx < 0) chk("done_latency", cyc, ROUNDS + 2);
      end
    end
    if (!fin) begin
      checks++; failures++;
      $display("FAIL timeout waiting for done_o, delivered=%0d", idx);
    end
    @(negedge clk);
    start_i = 1'b0;
    chk("ready_after_done", ready_o, 1'b1);
    chk("done_one_cycle", done_o, 1'b0);
    chk("valid_idle", subkey_valid_o, 1'b0);
  endtask

  typedef struct {
    logic        mode;
    int          idx;
    logic [4:0]  rnd;
    logic [47:0] sk;
    logic        last;
  } vec_t;
  vec_t vecs [6];

  initial begin
    int n;
    vecs[0] = '{1'b0, 0,  5'd1,  48'h1B02EFFC7072, 1'b0};
    vecs[1] = '{1'b0, 1,  5'd2,  48'h79AED9DBC9E5, 1'b0};
    vecs[2] = '{1'b0, 15, 5'd16, 48'hCB3D8B0E17F5, 1'b1};
    vecs[3] = '{1'b1, 0,  5'd16, 48'hCB3D8B0E17F5, 1'b0};
    vecs[4] = '{1'b1, 14, 5'd2,  48'h79AED9DBC9E5, 1'b0};
    vecs[5] = '{1'b1, 15, 5'd1,  48'h1B02EFFC7072, 1'b1};

    rst_n = 1'b0; clear_i = 1'b0; start_i = 1'b0; mode_i = 1'b0;
    key_i = 64'h0; subkey_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_valid", subkey_valid_o, 1'b0);
    chk("rst_subkey", subkey_o, 48'h0);
    chk("rst_round", round_o, 5'd0);
    chk("rst_last", last_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    rst_n = 1'b1;

    // Known-answer encrypt and decrypt, then the table and order-reversal checks.
    run_op(1'b0, KEY, 1'b0, -1, 1'b0);
    for (int i = 0; i < ROUNDS; i++) begin
      enc_sk[i] = cap_sk[i]; enc_rd[i] = cap_rd[i]; enc_last[i] = cap_last[i];
    end
    run_op(1'b1, KEY, 1'b0, -1, 1'b0);
    for (int i = 0; i < ROUNDS; i++) begin
      dec_sk[i] = cap_sk[i]; dec_rd[i] = cap_rd[i]; dec_last[i] = cap_last[i];
    end
    foreach (vecs[v]) begin
      if (vecs[v].mode) begin
        chk("kat_dec_round", dec_rd[vecs[v].idx], vecs[v].rnd);
        chk("kat_dec_subkey", dec_sk[vecs[v].idx], vecs[v].sk);
        chk("kat_dec_last", dec_last[vecs[v].idx], vecs[v].last);
      end else begin
        chk("kat_enc_round", enc_rd[vecs[v].idx], vecs[v].rnd);
        chk("kat_enc_subkey", enc_sk[vecs[v].idx], vecs[v].sk);
        chk("kat_enc_last", enc_last[vecs[v].idx], vecs[v].last);
      end
    end
    for (int i = 0; i < ROUNDS; i++) chk("dec_is_enc_reversed", dec_sk[i], enc_sk[ROUNDS - 1 - i]);

    // Backpressure on round 5, then start pulses with other keys during the run.
    run_op(1'b0, KEY, 1'b0, 4, 1'b0);
    run_op(1'b0, KEY, 1'b0, -1, 1'b1);

    // clear_i at round 9 while the output is stalled.
    @(negedge clk);
    start_i = 1'b1; mode_i = 1'b0; key_i = KEY; subkey_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(subkey_valid_o && round_o == 5'd9) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("clear_reached_round9", round_o, 5'd9);
    subkey_ready_i = 1'b0; clear_i = 1'b1; start_i = 1'b1; key_i = 64'h0123456789ABCDEF;
    @(negedge clk);
    chk("clear_valid", subkey_valid_o, 1'b0);
    chk("clear_ready", ready_o, 1'b1);
    chk("clear_last", last_o, 1'b0);
    chk("clear_done", done_o, 1'b0);
    // clear_i beats a simultaneous start_i in IDLE.
    @(negedge clk);
    chk("clear_wins_ready", ready_o, 1'b1);
    @(negedge clk);
    chk("clear_wins_valid", subkey_valid_o, 1'b0);
    clear_i = 1'b0; start_i = 1'b0; subkey_ready_i = 1'b1;
    run_op(1'b0, 64'h0123456789ABCDEF, 1'b0, -1, 1'b0);

    // Randomised keys, modes, backpressure and stray starts.
    for (int t = 0; t < 6; t++) run_op(1'($urandom), {$urandom, $urandom}, 1'b1, -1, 1'b1);

    // Asynchronous reset mid-run, then an all-zero key.
    @(negedge clk);
    start_i = 1'b1; mode_i = 1'b0; key_i = KEY; subkey_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", ready_o, 1'b1);
    chk("arst_valid", subkey_valid_o, 1'b0);
    chk("arst_subkey", subkey_o, 48'h0);
    chk("arst_round", round_o, 5'd0);
    chk("arst_last", last_o, 1'b0);
    chk("arst_done", done_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 64'h0, 1'b0, -1, 1'b0);
    for (int i = 0; i < ROUNDS; i++) chk("zero_key_subkey", cap_sk[i], 48'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
